// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and the bubble constant for the ID/EX pipeline stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_stage_pkg;

   // Write-back data select
   localparam logic [1:0] WD_FROM_ALU = 2'b00;
   localparam logic [1:0] WD_FROM_MEM = 2'b01;
   localparam logic [1:0] WD_FROM_PC  = 2'b10;

   // Next-PC select
   localparam logic [2:0] NPC_PLUS4  = 3'b000;
   localparam logic [2:0] NPC_BRANCH = 3'b001;
   localparam logic [2:0] NPC_JUMP   = 3'b010;
   localparam logic [2:0] NPC_JALR   = 3'b100;

   // Decoder control bundle carried through the stage
   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic [4:0] alu_op;
      logic [2:0] npc_op;
      logic       alu_src;
      logic [2:0] dm_type;
      logic [1:0] wd_sel;
      logic [1:0] gpr_sel;
   } ctrl_t;

   // Control values of an inserted bubble: no write-back, no store, sequential PC
   localparam ctrl_t CTRL_BUBBLE = '{
      reg_write: 1'b0,
      mem_write: 1'b0,
      alu_op:    5'd0,
      npc_op:    NPC_PLUS4,
      alu_src:   1'b0,
      dm_type:   3'd0,
      wd_sel:    WD_FROM_ALU,
      gpr_sel:   2'd0
   };

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector between the EX-stage load and the ID-stage reader.
// Latency: purely combinational.
// Backpressure: stall_o tells PC and IF/ID to hold while EX becomes a bubble.
module load_use_detect
   import id_ex_stage_pkg::*;
(
   input  logic       ex_valid_i,
   input  logic [1:0] ex_wdsel_i,
   input  logic [4:0] ex_rd_i,
   input  logic       id_valid_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   output logic       stall_o
);

   // A load into a real register that the next instruction reads must stall one cycle
   always_comb begin
      stall_o = ex_valid_i
             && (ex_wdsel_i == WD_FROM_MEM)
             && (ex_rd_i != 5'd0)
             && id_valid_i
             && ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and hold handling.
// Latency: 1 cycle from ID inputs to EX outputs.
// Backpressure: hold_i freezes the stage; stall_o is raised to hold PC and IF/ID.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            id_valid_i,
   input  logic [XLEN-1:0] id_pc_i,
   input  logic [XLEN-1:0] id_rs1_data_i,
   input  logic [XLEN-1:0] id_rs2_data_i,
   input  logic [XLEN-1:0] id_imm_i,
   input  logic [4:0]      id_rs1_i,
   input  logic [4:0]      id_rs2_i,
   input  logic [4:0]      id_rd_i,
   input  logic            RegWrite_i,
   input  logic            MemWrite_i,
   input  logic [4:0]      ALUOp_i,
   input  logic [2:0]      NPCOp_i,
   input  logic            ALUSrc_i,
   input  logic [2:0]      DMType_i,
   input  logic [1:0]      WDSel_i,
   input  logic [1:0]      GPRSel_i,
   input  logic            flush_i,
   input  logic            hold_i,
   output logic            ex_valid_o,
   output logic [XLEN-1:0] ex_pc_o,
   output logic [XLEN-1:0] ex_rs1_data_o,
   output logic [XLEN-1:0] ex_rs2_data_o,
   output logic [XLEN-1:0] ex_imm_o,
   output logic [4:0]      ex_rs1_o,
   output logic [4:0]      ex_rs2_o,
   output logic [4:0]      ex_rd_o,
   output logic            RegWrite_o,
   output logic            MemWrite_o,
   output logic [4:0]      ALUOp_o,
   output logic [2:0]      NPCOp_o,
   output logic            ALUSrc_o,
   output logic [2:0]      DMType_o,
   output logic [1:0]      WDSel_o,
   output logic [1:0]      GPRSel_o,
   output logic            stall_o,
   output logic [31:0]     bubble_cnt_o
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      ctrl_t           ctrl;
   } ex_t;

   localparam ex_t EX_BUBBLE = '{ctrl: CTRL_BUBBLE, default: '0};

   ex_t         ex_d, ex_q;
   ex_t         id_ex;
   logic [31:0] bubble_cnt_d, bubble_cnt_q;
   logic        stall;

   load_use_detect u_load_use_detect (
      .ex_valid_i (ex_q.valid),
      .ex_wdsel_i (ex_q.ctrl.wd_sel),
      .ex_rd_i    (ex_q.rd),
      .id_valid_i (id_valid_i),
      .id_rs1_i   (id_rs1_i),
      .id_rs2_i   (id_rs2_i),
      .stall_o    (stall)
   );

   // Next EX contents and bubble count: flush beats hold beats stall beats capture
   always_comb begin
      ex_d         = ex_q;
      bubble_cnt_d = bubble_cnt_q;

      id_ex.valid          = 1'b1;
      id_ex.pc             = id_pc_i;
      id_ex.rs1_data       = id_rs1_data_i;
      id_ex.rs2_data       = id_rs2_data_i;
      id_ex.imm            = id_imm_i;
      id_ex.rs1            = id_rs1_i;
      id_ex.rs2            = id_rs2_i;
      id_ex.rd             = id_rd_i;
      id_ex.ctrl.reg_write = RegWrite_i;
      id_ex.ctrl.mem_write = MemWrite_i;
      id_ex.ctrl.alu_op    = ALUOp_i;
      id_ex.ctrl.npc_op    = NPCOp_i;
      id_ex.ctrl.alu_src   = ALUSrc_i;
      id_ex.ctrl.dm_type   = DMType_i;
      id_ex.ctrl.wd_sel    = WDSel_i;
      id_ex.ctrl.gpr_sel   = GPRSel_i;

      if (flush_i) begin
         ex_d         = EX_BUBBLE;
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else if (hold_i) begin
         ex_d         = ex_q;
      end else if (stall) begin
         ex_d         = EX_BUBBLE;
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else if (id_valid_i) begin
         ex_d         = id_ex;
      end else begin
         // Empty ID slot: bubble without counting it as an inserted one
         ex_d         = EX_BUBBLE;
      end
   end

   // Pipeline register and bubble counter, cleared to bubble state by reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ex_q         <= EX_BUBBLE;
         bubble_cnt_q <= 32'd0;
      end else begin
         ex_q         <= ex_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ex_valid_o    = ex_q.valid;
   assign ex_pc_o       = ex_q.pc;
   assign ex_rs1_data_o = ex_q.rs1_data;
   assign ex_rs2_data_o = ex_q.rs2_data;
   assign ex_imm_o      = ex_q.imm;
   assign ex_rs1_o      = ex_q.rs1;
   assign ex_rs2_o      = ex_q.rs2;
   assign ex_rd_o       = ex_q.rd;
   assign RegWrite_o    = ex_q.ctrl.reg_write;
   assign MemWrite_o    = ex_q.ctrl.mem_write;
   assign ALUOp_o       = ex_q.ctrl.alu_op;
   assign NPCOp_o       = ex_q.ctrl.npc_op;
   assign ALUSrc_o      = ex_q.ctrl.alu_src;
   assign DMType_o      = ex_q.ctrl.dm_type;
   assign WDSel_o       = ex_q.ctrl.wd_sel;
   assign GPRSel_o      = ex_q.ctrl.gpr_sel;
   assign stall_o       = stall;
   assign bubble_cnt_o  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a queue-based scoreboard.
// Driver issues one vector per cycle and queues the expected EX state.
// Monitor pops and compares one entry after every rising edge.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rstn;
   logic        id_valid_i;
   logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
   logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
   logic        RegWrite_i, MemWrite_i, ALUSrc_i;
   logic [4:0]  ALUOp_i;
   logic [2:0]  NPCOp_i, DMType_i;
   logic [1:0]  WDSel_i, GPRSel_i;
   logic        flush_i, hold_i;
   logic        ex_valid_o;
   logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
   logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
   logic        RegWrite_o, MemWrite_o, ALUSrc_o;
   logic [4:0]  ALUOp_o;
   logic [2:0]  NPCOp_o, DMType_o;
   logic [1:0]  WDSel_o, GPRSel_o;
   logic        stall_o;
   logic [31:0] bubble_cnt_o;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32)) dut (
      .clk(clk), .rstn(rstn),
      .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
      .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
      .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .ALUOp_i(ALUOp_i),
      .NPCOp_i(NPCOp_i), .ALUSrc_i(ALUSrc_i), .DMType_i(DMType_i),
      .WDSel_i(WDSel_i), .GPRSel_i(GPRSel_i),
      .flush_i(flush_i), .hold_i(hold_i),
      .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
      .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
      .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
      .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o), .ALUOp_o(ALUOp_o),
      .NPCOp_o(NPCOp_o), .ALUSrc_o(ALUSrc_o), .DMType_o(DMType_o),
      .WDSel_o(WDSel_o), .GPRSel_o(GPRSel_o),
      .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1_data, rs2_data, imm;
      logic [4:0]  rs1, rs2, rd;
      logic        rw, mw;
      logic [4:0]  aluop;
      logic [2:0]  npc;
      logic        alusrc;
      logic [2:0]  dmt;
      logic [1:0]  wd, gpr;
   } vec_t;

   typedef struct {
      vec_t        v;
      logic [31:0] cnt;
   } exp_t;

   localparam vec_t BUB = '0;
   localparam logic [4:0] OP_ADD  = 5'd2;
   localparam logic [4:0] OP_ADDI = 5'd3;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [1:0] wd, input logic [4:0] aluop);
      vec_t r;
      r          = '0;
      r.valid    = 1'b1;
      r.pc       = pc;
      r.rs1_data = 32'hA000_0000 | pc;
      r.rs2_data = 32'hB000_0000 | pc;
      r.imm      = 32'h0000_0C00 | pc;
      r.rs1      = rs1;
      r.rs2      = rs2;
      r.rd       = rd;
      r.rw       = 1'b1;
      r.mw       = pc[2];
      r.aluop    = aluop;
      r.npc      = pc[4:2];
      r.alusrc   = (aluop == OP_ADDI);
      r.dmt      = (wd == 2'b01) ? 3'b010 : 3'b000;
      r.wd       = wd;
      r.gpr      = pc[3:2];
      return r;
   endfunction

   task automatic apply(input vec_t x);
      id_valid_i    = x.valid;
      id_pc_i       = x.pc;
      id_rs1_data_i = x.rs1_data;
      id_rs2_data_i = x.rs2_data;
      id_imm_i      = x.imm;
      id_rs1_i      = x.rs1;
      id_rs2_i      = x.rs2;
      id_rd_i       = x.rd;
      RegWrite_i    = x.rw;
      MemWrite_i    = x.mw;
      ALUOp_i       = x.aluop;
      NPCOp_i       = x.npc;
      ALUSrc_i      = x.alusrc;
      DMType_i      = x.dmt;
      WDSel_i       = x.wd;
      GPRSel_i      = x.gpr;
   endtask

   // One cycle of stimulus: apply, check combinational stall, queue expected EX state
   task automatic drive(input vec_t x, input logic fl, input logic hd, input logic st,
                        input vec_t ev, input logic [31:0] ec);
      exp_t e;
      @(negedge clk);
      apply(x);
      flush_i = fl;
      hold_i  = hd;
      #1;
      chk("stall_o", 32'(stall_o), 32'(st));
      e.v   = ev;
      e.cnt = ec;
      sb_q.push_back(e);
   endtask

   // Monitor: one expected entry per edge that had stimulus queued
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("ex_valid_o",    32'(ex_valid_o),   32'(e.v.valid));
            chk("ex_pc_o",       ex_pc_o,           e.v.pc);
            chk("ex_rs1_data_o", ex_rs1_data_o,     e.v.rs1_data);
            chk("ex_rs2_data_o", ex_rs2_data_o,     e.v.rs2_data);
            chk("ex_imm_o",      ex_imm_o,          e.v.imm);
            chk("ex_rs1_o",      32'(ex_rs1_o),     32'(e.v.rs1));
            chk("ex_rs2_o",      32'(ex_rs2_o),     32'(e.v.rs2));
            chk("ex_rd_o",       32'(ex_rd_o),      32'(e.v.rd));
            chk("RegWrite_o",    32'(RegWrite_o),   32'(e.v.rw));
            chk("MemWrite_o",    32'(MemWrite_o),   32'(e.v.mw));
            chk("ALUOp_o",       32'(ALUOp_o),      32'(e.v.aluop));
            chk("NPCOp_o",       32'(NPCOp_o),      32'(e.v.npc));
            chk("ALUSrc_o",      32'(ALUSrc_o),     32'(e.v.alusrc));
            chk("DMType_o",      32'(DMType_o),     32'(e.v.dmt));
            chk("WDSel_o",       32'(WDSel_o),      32'(e.v.wd));
            chk("GPRSel_o",      32'(GPRSel_o),     32'(e.v.gpr));
            chk("bubble_cnt_o",  bubble_cnt_o,      e.cnt);
         end
      end
   end

   initial begin
      vec_t a, l5, u, l0, b7, i5, c8, inv, l9, d10, l11, h, e12, f, l13, r, n14;
      exp_t e;
      a   = mk(32'h10, 5'd1,  5'd2, 5'd3,  2'b00, OP_ADD);   // add x3,x1,x2
      l5  = mk(32'h14, 5'd1,  5'd0, 5'd5,  2'b01, OP_ADD);   // lw x5
      u   = mk(32'h18, 5'd5,  5'd2, 5'd6,  2'b00, OP_ADD);   // uses x5
      l0  = mk(32'h1c, 5'd1,  5'd0, 5'd0,  2'b01, OP_ADD);   // lw x0
      b7  = mk(32'h20, 5'd0,  5'd0, 5'd7,  2'b00, OP_ADD);   // reads x0
      i5  = mk(32'h24, 5'd7,  5'd0, 5'd5,  2'b00, OP_ADDI);  // addi x5
      c8  = mk(32'h28, 5'd5,  5'd0, 5'd8,  2'b00, OP_ADD);   // reads x5 after addi
      inv = mk(32'h2c, 5'd8,  5'd8, 5'd20, 2'b00, OP_ADD);
      inv.valid = 1'b0;
      l9  = mk(32'h30, 5'd1,  5'd0, 5'd9,  2'b01, OP_ADD);   // lw x9
      d10 = mk(32'h34, 5'd3,  5'd9, 5'd10, 2'b00, OP_ADD);   // reads x9 via rs2
      l11 = mk(32'h38, 5'd1,  5'd0, 5'd11, 2'b01, OP_ADD);   // lw x11
      h   = mk(32'h3c, 5'd11, 5'd0, 5'd15, 2'b00, OP_ADD);   // reads x11
      e12 = mk(32'h40, 5'd1,  5'd2, 5'd12, 2'b00, OP_ADD);
      f   = mk(32'h44, 5'd1,  5'd2, 5'd16, 2'b00, OP_ADD);
      l13 = mk(32'h48, 5'd1,  5'd0, 5'd13, 2'b01, OP_ADD);   // lw x13
      r   = mk(32'h4c, 5'd13, 5'd0, 5'd17, 2'b00, OP_ADD);   // reads x13
      n14 = mk(32'h50, 5'd1,  5'd2, 5'd14, 2'b00, OP_ADD);

      rstn    = 1'b0;
      flush_i = 1'b0;
      hold_i  = 1'b0;
      apply(BUB);
      #2;
      chk("rst_valid", 32'(ex_valid_o), 32'd0);
      chk("rst_cnt",   bubble_cnt_o,    32'd0);
      chk("rst_stall", 32'(stall_o),    32'd0);
      @(negedge clk);
      rstn = 1'b1;

      drive(a,   1'b0, 1'b0, 1'b0, a,   32'd0);
      drive(l5,  1'b0, 1'b0, 1'b0, l5,  32'd0);
      drive(u,   1'b0, 1'b0, 1'b1, BUB, 32'd1);   // load-use stall
      drive(u,   1'b0, 1'b0, 1'b0, u,   32'd1);   // held instruction now captured
      drive(l0,  1'b0, 1'b0, 1'b0, l0,  32'd1);
      drive(b7,  1'b0, 1'b0, 1'b0, b7,  32'd1);   // lw x0 never stalls
      drive(i5,  1'b0, 1'b0, 1'b0, i5,  32'd1);
      drive(c8,  1'b0, 1'b0, 1'b0, c8,  32'd1);   // non-load producer never stalls
      drive(inv, 1'b0, 1'b0, 1'b0, BUB, 32'd1);   // empty slot, not counted
      drive(l9,  1'b0, 1'b0, 1'b0, l9,  32'd1);
      drive(d10, 1'b1, 1'b1, 1'b1, BUB, 32'd2);   // flush+hold+stall counts once
      drive(l11, 1'b0, 1'b0, 1'b0, l11, 32'd2);
      for (int k = 0; k < 3; k++)
         drive(h, 1'b0, 1'b1, 1'b1, l11, 32'd2);  // hold freezes, stall still visible
      drive(e12, 1'b0, 1'b0, 1'b0, e12, 32'd2);
      drive(f,   1'b1, 1'b0, 1'b0, BUB, 32'd3);   // flush alone
      drive(l13, 1'b0, 1'b0, 1'b0, l13, 32'd3);

      // Asynchronous reset between edges with a valid load in EX
      @(negedge clk);
      apply(r);
      flush_i = 1'b0;
      hold_i  = 1'b0;
      #1;
      chk("pre_rst_stall", 32'(stall_o), 32'd1);
      #1;
      rstn = 1'b0;
      #1;
      chk("arst_valid",    32'(ex_valid_o), 32'd0);
      chk("arst_pc",       ex_pc_o,         32'd0);
      chk("arst_rd",       32'(ex_rd_o),    32'd0);
      chk("arst_regwrite", 32'(RegWrite_o), 32'd0);
      chk("arst_wdsel",    32'(WDSel_o),    32'd0);
      chk("arst_rs1_data", ex_rs1_data_o,   32'd0);
      chk("arst_cnt",      bubble_cnt_o,    32'd0);
      chk("arst_stall",    32'(stall_o),    32'd0);
      #1;
      rstn  = 1'b1;
      e.v   = r;
      e.cnt = 32'd0;
      sb_q.push_back(e);                          // first edge after reset captures
      drive(n14, 1'b0, 1'b0, 1'b0, n14, 32'd0);

      // Counter wrap: preload the counter while the stage is held
      @(negedge clk);
      hold_i = 1'b1;
      force dut.bubble_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.bubble_cnt_q;
      e.v   = n14;
      e.cnt = 32'hFFFF_FFFF;
      sb_q.push_back(e);
      drive(a, 1'b1, 1'b0, 1'b0, BUB, 32'd0);     // wraps to zero
      drive(a, 1'b1, 1'b0, 1'b0, BUB, 32'd1);
      drive(a, 1'b0, 1'b0, 1'b0, a,   32'd1);

      repeat (2) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have inputs id_valid_i 1, id_pc_i XLEN, id_rs1_data_i XLEN, id_rs2_data_i XLEN, id_imm_i XLEN, id_rs1_i 5, id_rs2_i 5, id_rd_i 5: decoded ID-stage instruction.
REQ-005 SHALL have control inputs from the decoder: RegWrite_i 1, MemWrite_i 1, ALUOp_i 5, NPCOp_i 3, ALUSrc_i 1, DMType_i 3, WDSel_i 2, GPRSel_i 2.
REQ-006 SHALL have inputs flush_i 1 (branch/jump taken in EX) and hold_i 1 (downstream backpressure).
REQ-007 SHALL have registered outputs ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o and the eight control signals suffixed _o, same widths as inputs.
REQ-008 SHALL have output stall_o 1 (combinational load-use stall to PC and IF/ID) and bubble_cnt_o 32 (registered inserted-bubble count).

Function
REQ-009 SHALL capture ID inputs into EX outputs on the rising clk edge, latency exactly 1 cycle.
REQ-010 SHALL assert stall_o when ex_valid_o=1, ex_WDSel_o=2'b01 (load), ex_rd_o!=0, id_valid_i=1, and ex_rd_o equals id_rs1_i or id_rs2_i.
REQ-011 SHALL NOT assert stall_o when ex_rd_o=0 or the EX instruction is not a load.
REQ-012 Per-edge priority SHALL be: flush_i > hold_i > stall_o > normal capture.
REQ-013 flush_i=1: next state SHALL be a bubble regardless of hold_i or stall_o.
REQ-014 hold_i=1 (no flush): all EX registers and bubble_cnt_o SHALL keep their values; stall_o still computed from held EX contents.
REQ-015 stall_o=1 (no flush, no hold): next state SHALL be a bubble; ID inputs are not captured (IF/ID holds them externally).
REQ-016 Bubble SHALL mean ex_valid_o=0, RegWrite_o=0, MemWrite_o=0, NPCOp_o=3'b000, WDSel_o=2'b00, ALUOp_o=0, ALUSrc_o=0, DMType_o=0, GPRSel_o=0, ex_rd_o=0; data fields zero.
REQ-017 id_valid_i=0 during normal capture SHALL produce a bubble.
REQ-018 bubble_cnt_o SHALL increment by 1 on every edge that loads a bubble due to stall_o or flush_i, wrapping 0xFFFFFFFF->0; bubbles from id_valid_i=0 SHALL NOT count.
REQ-019 Simultaneous flush_i and stall_o SHALL count once.

Reset
REQ-020 rstn=0 SHALL immediately force every EX register to bubble values (REQ-016) and bubble_cnt_o to 0, independent of clk.
REQ-021 stall_o SHALL be 0 while in reset (follows ex_valid_o=0).
REQ-022 Reset deassertion mid-stream SHALL resume normal capture on the first following edge.

Structure
REQ-023 Shared package SHALL hold WDSel encodings (FromALU 00, FromMEM 01, FromPC 10), NPCOp encodings (PLUS4 000, BRANCH 001, JUMP 010, JALR 100) and bubble constant.
REQ-024 Hazard detection SHALL be one sub-module, load_use_detect, purely combinational; pipeline registers and counter stay in id_ex_stage.

Verification
REQ-025 Normal: id_pc_i=0x10, add x3,x1,x2 controls (RegWrite=1, ALUOp=add) -> next cycle ex_pc_o=0x10, ex_rd_o=3, RegWrite_o=1, ex_valid_o=1.
REQ-026 Load-use: EX holds lw x5 (WDSel=01, rd=5), ID has rs1=5 -> stall_o=1, next cycle bubble, bubble_cnt_o=1; ID instruction then captured following cycle.
REQ-027 No hazard: EX holds lw x0 with ID rs1=0, or EX addi rd=5 with ID rs1=5 -> stall_o=0, capture normal.
REQ-028 Priority: flush_i=1, hold_i=1, stall_o=1 same edge -> bubble, bubble_cnt_o increments by exactly 1; hold_i alone -> outputs unchanged over 3 cycles.
REQ-029 Reset: rstn pulled low between edges with valid EX contents -> outputs bubble and bubble_cnt_o=0 before next edge.
REQ-030 Wrap: preload bubble_cnt_o to 0xFFFFFFFF via forced flushes -> one more flush yields 0.
